// File: rtl/btn_intr_ctrl.sv
// rtl/btn_intr_ctrl.sv - debounced button pulse to held CPU interrupt request with pending count and holdoff
// Optional ack-timeout withdrawal is built when INTR_TIMEOUT_EN is defined.
module btn_intr_ctrl #(
    parameter int PEND_W       = 4,
    parameter int HOLDOFF_CLKS = 8,
    parameter int TIMEOUT_CLKS = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EVT,
    input  logic              INTR_EN,
    input  logic              INTR_ACK,
    input  logic              CLR_OVF,
    output logic              INTR,
    output logic [PEND_W-1:0] PEND_CNT,
    output logic              OVERFLOW
);

    localparam int HW = $clog2(HOLDOFF_CLKS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            evt_q;
    logic            rise;
    logic            dec;
    logic [HW-1:0]   hold_cnt;
    logic            hold_done;

`ifdef INTR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0]   to_cnt;
    logic            to_hit;
    assign to_hit = (to_cnt == TW'(TIMEOUT_CLKS - 1));
`endif

    assign rise      = EVT & ~evt_q;
    assign dec       = (state == REQ) & INTR_ACK;
    assign hold_done = (hold_cnt == HW'(HOLDOFF_CLKS - 1));
    assign INTR      = (state == REQ);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (PEND_CNT != '0 && INTR_EN)
                    state_nxt = REQ;
            end
            REQ: begin
                if (INTR_ACK)
                    state_nxt = HOLDOFF;
`ifdef INTR_TIMEOUT_EN
                else if (to_hit)
                    state_nxt = HOLDOFF;
`endif
                else if (!INTR_EN)
                    state_nxt = IDLE;
            end
            HOLDOFF: begin
                if (hold_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            evt_q    <= 1'b1;
            hold_cnt <= '0;
            PEND_CNT <= '0;
            OVERFLOW <= 1'b0;
`ifdef INTR_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            state    <= state_nxt;
            evt_q    <= EVT;
            // Counter idles at zero so HOLDOFF always starts counting from 0.
            hold_cnt <= (state == HOLDOFF) ? hold_cnt + 1'b1 : '0;
`ifdef INTR_TIMEOUT_EN
            to_cnt   <= (state == REQ) ? to_cnt + 1'b1 : '0;
`endif
            case ({rise, dec})
                2'b10: begin
                    if (!(&PEND_CNT))
                        PEND_CNT <= PEND_CNT + 1'b1;
                end
                2'b01: begin
                    if (PEND_CNT != '0)
                        PEND_CNT <= PEND_CNT - 1'b1;
                end
                default: ;
            endcase
            // A dropped event outranks a same-cycle clear so it is never lost.
            if (rise && !dec && (&PEND_CNT))
                OVERFLOW <= 1'b1;
            else if (CLR_OVF)
                OVERFLOW <= 1'b0;
        end
    end

endmodule
